dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port data memory (14-bit word address, 32-bit data) between NREQ requesters: the CPU load/store port and accelerator/DMA ports.
- Arbitration is round-robin.
- A requester can hold the port for a burst of up to 16 beats.
- Read data returns one cycle after a granted read beat.
- Sits between the requesters and the data RAM macro.

Parameters:
NREQ, 2, number of requesters (2..8); index 0 is the CPU port.
BLEN_W, 4, width of burst-length field; burst of blen+1 beats.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req  in  NREQ  per-requester request, held until granted
we  in  NREQ  per-requester write enable for current beat
addr  in  NREQ x 14  per-requester word address for current beat
wdata  in  NREQ x 32  per-requester write data
blen  in  NREQ x BLEN_W  burst beats minus 1, sampled on first grant
gnt  out  NREQ  beat accepted this cycle (one-hot or zero)
rvalid  out  NREQ  read data valid for requester (one-hot or zero)
rdata  out  32  read data, shared, qualified by rvalid
mem_addr  out  14  RAM address
mem_we  out  1  RAM write enable
mem_d  out  32  RAM write data
mem_q  in  32  RAM read data, valid the cycle after address

Behaviour:
- Reset values: state IDLE, rr_ptr 0, beat_cnt 0, owner 0, rvalid 0.
- Reset outputs: gnt forced 0 while rst_n low; mem_we 0; mem_addr 0; mem_d 0.
- FSM has two states: IDLE and BURST.
- IDLE with no req:
  - gnt = 0, mem_we = 0.
  - mem_addr/mem_d hold their last value (registered-free mux default = owner's inputs).
- IDLE with any req:
  - Winner is the first set bit searching from rr_ptr upward with wrap-around (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
  - gnt[winner] = 1 combinationally in the same cycle, and the beat is issued to RAM that cycle.
  - Latch owner = winner and beat_cnt = blen[winner].
  - If blen = 0: stay in IDLE and set rr_ptr = winner+1 (mod NREQ).
  - Otherwise: go to BURST.
- BURST, while req[owner] = 1:
  - gnt[owner] = 1 and the beat is issued.
  - beat_cnt decrements.
  - When beat_cnt reaches 1 → 0 on this beat, it is the last beat: go to IDLE and set rr_ptr = owner+1.
- BURST with req[owner] = 0: early termination.
  - No beat is issued; gnt = 0.
  - Go to IDLE and set rr_ptr = owner+1.
  - Arbitration restarts the next cycle; no same-cycle re-arbitration.
- Other requesters are never granted during BURST.
- The requester drives new addr/we/wdata on every beat. The RAM mux selects the owner in BURST and the winner in IDLE.
- Read return:
  - A granted beat with we = 0 sets rvalid[id] exactly one cycle later.
  - rdata = mem_q, passed combinationally, valid only when rvalid is set.
  - Write beats produce no rvalid.
- Back-to-back bursts from different requesters: read latency stays at 1. rvalid follows the requester of the previous cycle's beat, tracked in a registered id plus valid bit.
- Reset mid-burst: FSM returns to IDLE immediately and in-flight rvalid is dropped.
- A beat's write is committed on the same clock edge as its gnt.
- A single requester asserting req continuously with blen = 0 is granted every cycle only when it is the sole requester. Otherwise it alternates with the others.

Optional Feature:
DMEM_ARB_CPU_PRIO_EN:
- Defined: requester 0 (CPU) wins every IDLE arbitration it participates in, regardless of rr_ptr. rr_ptr advances only on non-CPU grants. Bursts in progress are never preempted.
- Undefined: pure round-robin for all requesters, including 0.

Decomposition:
- Shared package pkg_cpu_types receives:
  - arb_state_t enum {ARB_IDLE, ARB_BURST}
  - constants DMEM_AW = 14 and DMEM_DW = 32
- One natural sub-module: rr_picker. It is combinational, takes req vector and rr_ptr, and returns a one-hot winner plus an any bit. It is reusable for other shared resources.

Test Plan:
- Reset with req = 2'b11 held low-reset → gnt = 0, rvalid = 0. First cycle after release → gnt = 2'b01 (rr_ptr 0).
- Both req, blen = 0, continuous → gnt alternates 01,10,01,10. Each read's rvalid follows one cycle later with rdata = mem_q.
- Req1 burst blen = 3 at addr 0x10..0x13 while req0 also asserts → 4 consecutive gnt[1], then gnt[0]; rr_ptr = 0 after.
- Req0 write 0xDEADBEEF to 0x0005, then read 0x0005 → mem_we = 1 on write cycle; rvalid[0] cycle after read with rdata = 0xDEADBEEF.
- Burst blen = 7, req dropped after beat 3 → exactly 3 gnt pulses, FSM IDLE next cycle, other requester granted the cycle after.
- rst_n asserted mid-burst (beat 2 of 5) → gnt and rvalid 0 immediately; after release fresh arbitration from rr_ptr = 0.

Source files
------------

// File: rtl/pkg_cpu_types.sv
// Shared types for the data-memory path: arbiter FSM states and RAM geometry.
package pkg_cpu_types;
  localparam int DMEM_AW = 14;
  localparam int DMEM_DW = 32;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;
endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// Round-robin picker: first set req bit at or above ptr, wrapping; one-hot result.
module rr_picker #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win_oh,
  output logic          any
);
  always_comb begin
    win_oh = '0;
    any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any       = 1'b1;
        win_oh[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin, burst-capable arbiter for the single-port data RAM.
// Build option: DMEM_ARB_CPU_PRIO_EN gives requester 0 absolute priority in IDLE.
module dmem_arbiter
  import pkg_cpu_types::*;
#(
  parameter int NREQ   = 2,
  parameter int BLEN_W = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ-1:0]               we,
  input  logic [NREQ-1:0][DMEM_AW-1:0]  addr,
  input  logic [NREQ-1:0][DMEM_DW-1:0]  wdata,
  input  logic [NREQ-1:0][BLEN_W-1:0]   blen,
  output logic [NREQ-1:0]               gnt,
  output logic [NREQ-1:0]               rvalid,
  output logic [DMEM_DW-1:0]            rdata,
  output logic [DMEM_AW-1:0]            mem_addr,
  output logic                          mem_we,
  output logic [DMEM_DW-1:0]            mem_d,
  input  logic [DMEM_DW-1:0]            mem_q
);
  localparam int IW = $clog2(NREQ);
`ifdef DMEM_ARB_CPU_PRIO_EN
  localparam bit CPU_PRIO = 1'b1;
`else
  localparam bit CPU_PRIO = 1'b0;
`endif

  arb_state_t          state, state_n;
  logic [IW-1:0]       rr_ptr, rr_ptr_n, owner, owner_n, sel, rd_id;
  logic [IW-1:0]       pick_idx, win_idx;
  logic [BLEN_W-1:0]   beat_cnt, beat_cnt_n;
  logic [NREQ-1:0]     pick_oh;
  logic                pick_any, beat, rd_vld;

  rr_picker #(.N(NREQ)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .win_oh (pick_oh),
    .any    (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick_oh[i]) pick_idx = IW'(i);
  end

  // CPU override only affects the IDLE pick; bursts are never preempted.
  assign win_idx = (CPU_PRIO && req[0]) ? '0 : pick_idx;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] x);
    return (x == IW'(NREQ - 1)) ? '0 : x + 1'b1;
  endfunction

  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    owner_n    = owner;
    beat_cnt_n = beat_cnt;
    sel        = owner;
    beat       = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          sel        = win_idx;
          beat       = 1'b1;
          owner_n    = win_idx;
          beat_cnt_n = blen[win_idx];
          if (blen[win_idx] == '0) begin
            if (!CPU_PRIO || win_idx != '0) rr_ptr_n = nxt(win_idx);
          end else begin
            state_n = ARB_BURST;
          end
        end
      end
      ARB_BURST: begin
        // A dropped req ends the burst without a beat; no re-arbitration this cycle.
        if (req[owner]) begin
          beat       = 1'b1;
          beat_cnt_n = beat_cnt - 1'b1;
        end
        if (!req[owner] || beat_cnt == BLEN_W'(1)) begin
          state_n = ARB_IDLE;
          if (!CPU_PRIO || owner != '0) rr_ptr_n = nxt(owner);
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  assign gnt      = (beat && rst_n) ? (NREQ'(1) << sel) : '0;
  assign mem_we   = beat && rst_n && we[sel];
  assign mem_addr = rst_n ? addr[sel]  : '0;
  assign mem_d    = rst_n ? wdata[sel] : '0;
  assign rvalid   = rd_vld ? (NREQ'(1) << rd_id) : '0;
  assign rdata    = mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      rd_vld   <= 1'b0;
      rd_id    <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      owner    <= owner_n;
      beat_cnt <= beat_cnt_n;
      rd_vld   <= beat && !we[sel];
      rd_id    <= sel;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: scripted grant checks plus a read-return scoreboard.
module tb_dmem_arbiter;
  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req, we, gnt, rvalid;
  logic [1:0][13:0]  addr;
  logic [1:0][31:0]  wdata;
  logic [1:0][3:0]   blen;
  logic [31:0]       rdata, mem_d, mem_q;
  logic [13:0]       mem_addr;
  logic              mem_we;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
  } rd_exp_t;
  rd_exp_t     sbq[$];
  logic [31:0] ram[int];
  logic [31:0] shadow[int];

  always #5 clk = ~clk;

  dmem_arbiter #(.NREQ(2), .BLEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .blen(blen), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_d(mem_d), .mem_q(mem_q)
  );

  function automatic logic [31:0] init_val(input logic [13:0] a);
    return 32'hC0DE_0000 | {18'h0, a};
  endfunction

  function automatic logic [31:0] rd_shadow(input logic [13:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // RAM macro: synchronous read of the pre-write contents, write on the grant edge.
  initial begin
    mem_q = '0;
    forever begin
      @(posedge clk);
      mem_q = ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : init_val(mem_addr);
      if (mem_we) ram[int'(mem_addr)] = mem_d;
    end
  end

  // Scoreboard: each granted read expects rvalid/rdata on the following cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sbq.delete();
      end else begin
        if (sbq.size() > 0) begin
          rd_exp_t e;
          e = sbq.pop_front();
          chk("rv_id", rvalid, e.id);
          chk("rv_data", rdata, e.data);
        end else begin
          chk("rv_idle", rvalid, 2'b00);
        end
        for (int i = 0; i < 2; i++) begin
          if (gnt[i]) begin
            if (we[i]) shadow[int'(addr[i])] = wdata[i];
            else begin
              rd_exp_t n;
              n.id   = 2'(1 << i);
              n.data = rd_shadow(addr[i]);
              sbq.push_back(n);
            end
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 2'b11;
    we    = 2'b00;
    addr[0] = 14'h20;
    addr[1] = 14'h30;
    wdata = '0;
    blen  = '0;

    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_rv", rvalid, 2'b00);
      chk("rst_mwe", mem_we, 1'b0);
      chk("rst_maddr", mem_addr, 14'h0);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_gnt", gnt, 2'b01);

    // blen=0 from both: strict alternation
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("alt_gnt", gnt, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    tick();
    req = 2'b00;
    @(negedge clk);
    chk("idle_gnt", gnt, 2'b00);

    // requester 1 burst of 4 with requester 0 waiting
    tick();
    req = 2'b11;
    blen[1] = 4'd3;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) tick();
      addr[1] = 14'(16 + b);
      @(negedge clk);
      chk("bst_gnt", gnt, 2'b10);
      chk("bst_addr", mem_addr, 14'(16 + b));
    end
    tick();
    blen[1] = 4'd0;
    @(negedge clk);
    chk("post_bst_gnt", gnt, 2'b01);
    tick();
    req = 2'b00;

    // write then read back through requester 0
    tick();
    req = 2'b01;
    we  = 2'b01;
    addr[0]  = 14'h0005;
    wdata[0] = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_gnt", gnt, 2'b01);
    chk("wr_mwe", mem_we, 1'b1);
    chk("wr_md", mem_d, 32'hDEADBEEF);
    tick();
    we = 2'b00;
    @(negedge clk);
    chk("rd_gnt", gnt, 2'b01);
    chk("rd_mwe", mem_we, 1'b0);
    tick();
    req = 2'b00;
    @(negedge clk);
    chk("rd_rv", rvalid, 2'b01);
    chk("rd_data", rdata, 32'hDEADBEEF);

    // blen=7 burst abandoned after 3 beats
    tick();
    req = 2'b11;
    blen[1] = 4'd7;
    addr[0] = 14'h40;
    addr[1] = 14'h50;
    for (int b = 0; b < 3; b++) begin
      if (b > 0) tick();
      @(negedge clk);
      chk("et_gnt", gnt, 2'b10);
    end
    tick();
    req = 2'b01;
    @(negedge clk);
    chk("et_drop", gnt, 2'b00);
    tick();
    @(negedge clk);
    chk("et_next", gnt, 2'b01);
    tick();
    req  = 2'b00;
    blen = '0;

    // reset during beat 2 of a 5-beat burst
    tick();
    req = 2'b11;
    blen[1] = 4'd4;
    @(negedge clk);
    chk("mr_beat1", gnt, 2'b10);
    tick();
    @(negedge clk);
    chk("mr_beat2", gnt, 2'b10);
    chk("mr_rv_pre", rvalid, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_gnt", gnt, 2'b00);
    chk("mr_rv", rvalid, 2'b00);
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_rearb", gnt, 2'b01);
    tick();
    req = 2'b00;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
